// File: rtl/mem_access_stage.sv
// MEM stage: sized loads/stores over a dmem req/ready handshake; MEM_MISALIGN_TRAP_EN enables misalignment trapping.
// Latency: 3 cycles minimum per memory op (IDLE, ACCESS, RESP), plus 1 per dmem wait cycle; non-memory ops pass through combinationally.
// Backpressure: stall_out holds upstream from op issue until RESP; dmem_req is held with stable outputs until dmem_ready.
module mem_access_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_in,
  input  logic [31:0]           alu_result_in,
  input  logic [31:0]           store_data_in,
  input  logic [4:0]            register_destination_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_unsigned_in,
  input  logic                  memory_to_register_in,
  input  logic                  reg_write_in,
  input  logic                  overflow_flag_in,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ready,
  input  logic [31:0]           dmem_rdata,
  output logic [31:0]           pc_out,
  output logic [31:0]           memory_data_out,
  output logic [31:0]           alu_result_out,
  output logic [4:0]            register_destination_out,
  output logic                  memory_to_register_out,
  output logic                  reg_write_out,
  output logic                  overflow_flag_out,
  output logic                  stall_out,
  output logic                  misalign_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        op, misaligned, start, capture, stall, mis_flag;
  logic [1:0]  addr_lo;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [1:0]  size_q, lane_q;
  logic        unsigned_q;
  logic [31:0] load_q, ld_fmt, rd_shift;

  assign op      = mem_read_in | mem_write_in;
  assign addr_lo = alu_result_in[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (mem_size_in)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_lo[0];
      default: misaligned = |addr_lo;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Store lane steering: data replicated across lanes, enables pick the target bytes
  always_comb begin
    st_wdata = store_data_in;
    st_be    = 4'b1111;
    case (mem_size_in)
      2'b00: begin
        st_wdata = {4{store_data_in[7:0]}};
        st_be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        st_wdata = {2{store_data_in[15:0]}};
        st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = store_data_in;
        st_be    = 4'b1111;
      end
    endcase
  end

  assign rd_shift = dmem_rdata >> {lane_q, 3'b000};

  always_comb begin
    ld_fmt = dmem_rdata;
    case (size_q)
      2'b00:   ld_fmt = {{24{~unsigned_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_fmt = lane_q[1] ? {{16{~unsigned_q & dmem_rdata[31]}}, dmem_rdata[31:16]}
                                  : {{16{~unsigned_q & dmem_rdata[15]}}, dmem_rdata[15:0]};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    mis_flag = 1'b0;
    start    = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op) begin
          if (misaligned) begin
            mis_flag = 1'b1;
          end else begin
            start   = 1'b1;
            stall   = 1'b1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (dmem_ready) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      size_q     <= '0;
      lane_q     <= '0;
      unsigned_q <= 1'b0;
      load_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= mem_write_in;
        dmem_addr  <= {alu_result_in[ADDR_WIDTH-1:2], 2'b00};
        dmem_wdata <= st_wdata;
        dmem_be    <= st_be;
        size_q     <= mem_size_in;
        lane_q     <= addr_lo;
        unsigned_q <= mem_unsigned_in;
      end
      if (capture) begin
        dmem_req <= 1'b0;
        load_q   <= dmem_we ? 32'd0 : ld_fmt;
      end
    end
  end

  assign pc_out                   = pc_in;
  assign alu_result_out           = alu_result_in;
  assign register_destination_out = register_destination_in;
  assign memory_to_register_out   = memory_to_register_in;
  assign overflow_flag_out        = overflow_flag_in;
  assign memory_data_out          = (state_q == RESP) ? load_q : 32'd0;
  assign stall_out                = stall & ~rst;
  assign misalign_out             = mis_flag & ~rst;
  assign reg_write_out            = reg_write_in & ~stall & ~mis_flag & ~rst;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: scoreboard queues of expected dmem requests and load results.
module tb_mem_access_stage;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0, alu_result_in = '0, store_data_in = '0;
  logic [4:0]  register_destination_in = '0;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0, mem_unsigned_in = 1'b0;
  logic [1:0]  mem_size_in = '0;
  logic        memory_to_register_in = 1'b0, reg_write_in = 1'b0, overflow_flag_in = 1'b0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_be;
  logic [31:0] pc_out, memory_data_out, alu_result_out;
  logic [4:0]  register_destination_out;
  logic        memory_to_register_out, reg_write_out, overflow_flag_out, stall_out, misalign_out;

  int   total = 0;
  int   passed = 0;
  int   req_rises = 0;
  logic req_d = 1'b0;
  req_t exp_req_q[$];
  logic [31:0] exp_data_q[$];

  mem_access_stage #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .register_destination_in(register_destination_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_size_in(mem_size_in),
    .mem_unsigned_in(mem_unsigned_in), .memory_to_register_in(memory_to_register_in),
    .reg_write_in(reg_write_in), .overflow_flag_in(overflow_flag_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc_out(pc_out), .memory_data_out(memory_data_out), .alu_result_out(alu_result_out),
    .register_destination_out(register_destination_out),
    .memory_to_register_out(memory_to_register_out), .reg_write_out(reg_write_out),
    .overflow_flag_out(overflow_flag_out), .stall_out(stall_out), .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_req && !req_d) req_rises <= req_rises + 1;
    req_d <= dmem_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    if (sz == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return rd;
  endfunction

  function automatic req_t model_req(input logic wr, input logic [1:0] sz,
                                     input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.we   = wr;
    r.addr = {a[31:2], 2'b00};
    if (sz == 2'b00) begin
      r.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
      case (a[1:0])
        2'd0:    r.be = 4'h1;
        2'd1:    r.be = 4'h2;
        2'd2:    r.be = 4'h4;
        default: r.be = 4'h8;
      endcase
    end else if (sz == 2'b01) begin
      r.wdata = {d[15:0], d[15:0]};
      r.be    = a[1] ? 4'hC : 4'h3;
    end else begin
      r.wdata = d;
      r.be    = 4'hF;
    end
    return r;
  endfunction

  task automatic set_nop();
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_size_in = 2'b10; mem_unsigned_in = 1'b0;
    memory_to_register_in = 1'b0; reg_write_in = 1'b1;
    pc_in = pc_in + 32'd4; alu_result_in = 32'h0000_1234; register_destination_in = 5'd3;
  endtask

  // Called just after a rising edge with the stage idle; returns just after a rising edge.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                        input int waits, input logic rw);
    req_t got, first;
    int   stalls, rises0;
    mem_read_in = rd; mem_write_in = wr; mem_size_in = sz; mem_unsigned_in = uns;
    alu_result_in = addr; store_data_in = sdata; reg_write_in = rw;
    memory_to_register_in = rd; register_destination_in = 5'd7; pc_in = pc_in + 32'd4;
    exp_req_q.push_back(model_req(wr, sz, addr, sdata));
    exp_data_q.push_back(wr ? 32'd0 : model_load(sz, uns, addr, rdata));
    stalls = 0;
    rises0 = req_rises;
    @(negedge clk);
    if (stall_out) stalls++;
    chk("idle_req", 32'(dmem_req), 32'd0);
    chk("idle_regwrite", 32'(reg_write_out), 32'd0);
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      if (i == waits) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
      end
      @(negedge clk);
      if (stall_out) stalls++;
      chk("access_req", 32'(dmem_req), 32'd1);
      got = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata, be: dmem_be};
      if (i == 0) begin
        first = exp_req_q.pop_front();
        chk("req_we", 32'(got.we), 32'(first.we));
        chk("req_addr", got.addr, first.addr);
        chk("req_be", 32'(got.be), 32'(first.be));
        if (first.we) chk("req_wdata", got.wdata, first.wdata);
      end else begin
        chk("req_addr_stable", got.addr, first.addr);
      end
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    dmem_rdata = $urandom;
    @(negedge clk);
    if (stall_out) stalls++;
    chk("resp_req", 32'(dmem_req), 32'd0);
    chk("resp_data", memory_data_out, exp_data_q.pop_front());
    chk("resp_regwrite", 32'(reg_write_out), 32'(rw));
    chk("stall_cycles", 32'(stalls), 32'(2 + waits));
    chk("single_request", 32'(req_rises - rises0), 32'd1);
    @(posedge clk); #1;
    set_nop();
  endtask

  initial begin
    int rises0;
    #1 rst = 1'b1;
    mem_read_in = 1'b1; mem_size_in = 2'b10; alu_result_in = 32'h100; reg_write_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_regwrite", 32'(reg_write_out), 32'd0);
    chk("rst_misalign", 32'(misalign_out), 32'd0);
    chk("rst_memdata", memory_data_out, 32'd0);
    chk("rst_addr_be", {dmem_addr[27:0], dmem_be}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_nop();
    @(negedge clk);
    chk("nop_stall", 32'(stall_out), 32'd0);
    chk("nop_regwrite", 32'(reg_write_out), 32'd1);
    chk("nop_alu", alu_result_out, 32'h0000_1234);
    chk("nop_pc", pc_out, pc_in);
    chk("nop_memdata", memory_data_out, 32'd0);
    @(posedge clk); #1;

    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1);
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80112233, 0, 1'b1);
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80112233, 0, 1'b1);
    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h80112233, 0, 1'b1);
    run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h80112233, 1, 1'b1);
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0000007F, 0, 1'b1);
    run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB, 32'h0, 0, 1'b0);
    run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234CDEF, 32'h0, 0, 1'b0);
    run_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h104, 32'hA5A55A5A, 32'h0, 1, 1'b0);
    run_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h108, 32'h01020304, 32'hFFFFFFFF, 0, 1'b0);
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h13579BDF, 3, 1'b1);

`ifdef MEM_MISALIGN_TRAP_EN
    rises0 = req_rises;
    mem_read_in = 1'b1; mem_size_in = 2'b10; alu_result_in = 32'h101; reg_write_in = 1'b1;
    @(negedge clk);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_flag", 32'(misalign_out), 32'd1);
    chk("mis_stall", 32'(stall_out), 32'd0);
    chk("mis_regwrite", 32'(reg_write_out), 32'd0);
    chk("mis_memdata", memory_data_out, 32'd0);
    @(posedge clk); #1;
    set_nop();
    @(negedge clk);
    chk("mis_flag_clear", 32'(misalign_out), 32'd0);
    chk("mis_no_request", 32'(req_rises - rises0), 32'd0);
    @(posedge clk); #1;
`else
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1'b1);
    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 32'h80112233, 0, 1'b1);
`endif

    rises0 = req_rises;
    mem_read_in = 1'b1; mem_size_in = 2'b10; alu_result_in = 32'h300; reg_write_in = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_stall", 32'(stall_out), 32'd0);
    chk("midrst_regwrite", 32'(reg_write_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_nop();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h55;
    @(negedge clk);
    chk("post_rst_stall", 32'(stall_out), 32'd0);
    chk("post_rst_req", 32'(dmem_req), 32'd0);
    chk("post_rst_regwrite", 32'(reg_write_out), 32'd1);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    chk("late_ready_req", 32'(dmem_req), 32'd0);
    chk("late_ready_memdata", memory_data_out, 32'd0);
    chk("late_ready_norequest", 32'(req_rises - rises0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
